// File: rtl/multu_sequencer.sv
// Sequencer wrapped around the 32-bit shift-add Multiplier.
// It steps a MULTU through its clear, iterate and output phases, then captures the product into HI/LO.
module multu_sequencer #(
  parameter int          ITER      = 32,
  parameter logic [5:0]  SIG_IDLE  = 6'd0,
  parameter logic [5:0]  SIG_MULTU = 6'd25,
  parameter logic [5:0]  SIG_OUT   = 6'd63,
  parameter logic [5:0]  FN_MFHI   = 6'd16,
  parameter logic [5:0]  FN_MFLO   = 6'd18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  output logic [5:0]  mul_signal,
  output logic        mul_reset,
  input  logic [63:0] mul_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_OUTP,
    S_CAPT,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] count;
  logic       go;

  assign go = start && (funct == SIG_MULTU);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR)
        count <= '0;
      else if (state == S_RUN)
        count <= count + 6'd1;
      if (state == S_CAPT)
        {hi, lo} <= mul_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    mul_signal = SIG_IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        busy       = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        mul_signal = SIG_MULTU;
        if (count == LAST_ITER) state_next = S_OUTP;
      end
      S_OUTP: begin
        busy       = 1'b1;
        mul_signal = SIG_OUT;
        state_next = S_CAPT;
      end
      S_CAPT: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = go ? S_CLEAR : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The Multiplier is cleared together with this block and at the start of every operation.
  assign mul_reset = reset | (state == S_CLEAR);

  always_comb begin
    rdata = '0;
    if (funct == FN_MFHI)
      rdata = hi;
    else if (funct == FN_MFLO)
      rdata = lo;
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Bench for multu_sequencer: directed MULTU operations, with a scoreboard queue checked on every done pulse.
// Cycle index 0 is the cycle that presents start; the state is CLEAR at index 1 and DONE at index 36.
module tb_multu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [5:0]  mul_signal;
  logic        mul_reset;
  logic [63:0] mul_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];

  logic [5:0]  sig_t   [0:99];
  logic        rst_t   [0:99];
  logic        done_t  [0:99];
  logic        busy_t  [0:99];
  logic [31:0] rdata_t [0:99];
  logic [31:0] hi_t    [0:99];
  logic [31:0] lo_t    [0:99];

  multu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct     (funct),
    .mul_signal(mul_signal),
    .mul_reset (mul_reset),
    .mul_data  (mul_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT flags done, compare HI/LO against the oldest expected product.
  always @(negedge clk) begin
    #2;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_done", 64'(done), 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_hi", 64'(hi), 64'(e[63:32]));
        check("sb_lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  task automatic idle(input int n, input logic [5:0] fn);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      funct = fn;
      reset = 1'b0;
    end
  endtask

  task automatic issue(input logic [63:0] d, input bit expect_done);
    @(negedge clk);
    start    = 1'b1;
    funct    = 6'd25;
    reset    = 1'b0;
    mul_data = d;
    if (expect_done) exp_q.push_back(d);
  endtask

  // Steps n cycles after issue(), optionally pulsing start, reset or switching mul_data, and records outputs.
  task automatic trace(input int n, input int p1, input int p2, input int rst_at,
                       input int sw_at, input logic [63:0] d2, input logic [5:0] rd_fn);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = (i == p1) || (i == p2);
      funct = start ? 6'd25 : rd_fn;
      reset = (i == rst_at);
      if (sw_at != 0 && i >= sw_at) mul_data = d2;
      #1;
      sig_t[i]   = mul_signal;
      rst_t[i]   = mul_reset;
      done_t[i]  = done;
      busy_t[i]  = busy;
      rdata_t[i] = rdata;
      hi_t[i]    = hi;
      lo_t[i]    = lo;
    end
  endtask

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (done_t[i]) c++;
    return c;
  endfunction

  function automatic int count_rst(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (rst_t[i]) c++;
    return c;
  endfunction

  initial begin
    int run_cnt;
    int d1;
    int d2;

    start    = 1'b0;
    funct    = 6'd0;
    reset    = 1'b1;
    mul_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    idle(2, 6'd0);
    #1;
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_signal",     64'(mul_signal), 64'd0);
    check("rst_mul_reset0", 64'(mul_reset),  64'd0);
    check("rst_hilo",       {hi, lo},        64'd0);

    // Single operation 3*5, reading LO through the DONE cycle
    issue(64'd15, 1'b1);
    trace(40, 0, 0, 0, 0, '0, 6'd18);
    check("t1_busy_next",  64'(busy_t[1]), 64'd1);
    check("t1_clear_rst",  64'(rst_t[1]),  64'd1);
    check("t1_rst_cycles", 64'(count_rst(40)), 64'd1);
    run_cnt = 0;
    for (int i = 2; i <= 33; i++) if (sig_t[i] == 6'd25) run_cnt++;
    check("t1_run_cycles", 64'(run_cnt),    64'd32);
    check("t1_pre_run",    64'(sig_t[1]),   64'd0);
    check("t1_out_sig",    64'(sig_t[34]),  64'd63);
    check("t1_capt_sig",   64'(sig_t[35]),  64'd0);
    check("t1_capt_busy",  64'(busy_t[35]), 64'd1);
    check("t1_done_at36",  64'(done_t[36]), 64'd1);
    check("t1_done_busy",  64'(busy_t[36]), 64'd0);
    check("t1_done_count", 64'(count_done(40)), 64'd1);
    check("t1_lo_old_capt", 64'(rdata_t[35]), 64'd0);
    check("t1_lo_in_done",  64'(rdata_t[36]), 64'd15);
    idle(1, 6'd16);
    #1;
    check("t2_mfhi", 64'(rdata), 64'd0);
    idle(1, 6'd18);
    #1;
    check("t2_mflo", 64'(rdata), 64'd15);
    check("t2_hilo", {hi, lo}, 64'd15);

    // Largest product FFFFFFFF^2
    issue(64'hFFFFFFFE_00000001, 1'b1);
    trace(38, 0, 0, 0, 0, '0, 6'd16);
    check("t3_hi_before", 64'(rdata_t[35]), 64'd0);
    check("t3_hi_done",   64'(rdata_t[36]), 64'hFFFFFFFE);
    check("t3_hilo",      {hi, lo}, 64'hFFFFFFFE_00000001);

    // Start while busy is ignored; MFHI funct with start in IDLE is ignored
    issue(64'h00000001_23456789, 1'b1);
    trace(80, 5, 20, 0, 0, '0, 6'd18);
    check("t4_done_at36",  64'(done_t[36]), 64'd1);
    check("t4_done_count", 64'(count_done(80)), 64'd1);
    check("t4_rst_cycles", 64'(count_rst(80)), 64'd1);
    check("t4_idle_busy",  64'(busy_t[40]), 64'd0);
    @(negedge clk);
    start = 1'b1;
    funct = 6'd16;
    idle(1, 6'd0);
    #1;
    check("t4_fn16_busy",   64'(busy),       64'd0);
    check("t4_fn16_mrst",   64'(mul_reset),  64'd0);
    check("t4_fn16_signal", 64'(mul_signal), 64'd0);
    idle(3, 6'd0);
    #1;
    check("t4_fn16_hold", {hi, lo}, 64'h00000001_23456789);

    // Reset during RUN cycle 10 aborts the operation and clears HI/LO
    issue(64'hDEADBEEF_CAFEF00D, 1'b0);
    trace(50, 0, 0, 11, 0, '0, 6'd0);
    check("t5_run_before", 64'(sig_t[11]), 64'd25);
    check("t5_rst_high",   64'(rst_t[11]), 64'd1);
    check("t5_hi_kept",    64'(hi_t[11]),  64'd1);
    check("t5_idle_busy",  64'(busy_t[12]), 64'd0);
    check("t5_idle_sig",   64'(sig_t[12]),  64'd0);
    check("t5_hilo_clr",   {hi_t[12], lo_t[12]}, 64'd0);
    check("t5_no_done",    64'(count_done(50)), 64'd0);

    // Back-to-back: start during DONE goes straight to CLEAR
    issue(64'h00000000_00000007, 1'b1);
    exp_q.push_back(64'h00000002_00000009);
    trace(80, 36, 0, 0, 37, 64'h00000002_00000009, 6'd0);
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 80; i++) begin
      if (done_t[i]) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    check("t6_first_done", 64'(d1), 64'd36);
    check("t6_clear_rst",  64'(rst_t[37]),  64'd1);
    check("t6_clear_busy", 64'(busy_t[37]), 64'd1);
    check("t6_spacing",    64'(d2 - d1),    64'd36);
    check("t6_done_count", 64'(count_done(80)), 64'd2);

    idle(3, 6'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
